// File: rtl/memory_unit_pkg.sv
// rtl/memory_unit_pkg.sv - types, defaults and address-fault helper for memory_unit
`include "memory_defs.vh"

package memory_unit_pkg;

  localparam int DEF_ADDR_WIDTH  = `MEM_ADDR_WIDTH;
  localparam int DEF_WAIT_CYCLES = `MEM_WAIT_CYCLES;
  localparam int DATA_WIDTH      = 32;

  typedef enum logic [1:0] {
    IDLE   = `MEM_STATE_IDLE,
    ACCESS = `MEM_STATE_ACCESS,
    DONE   = `MEM_STATE_DONE
  } state_t;

  // Faulted when not word aligned or outside the 2**aw word window.
  function automatic logic addr_fault(input logic [31:0] addr, input int aw);
    logic [31:0] upper;
    upper = addr >> (aw + 2);
    return (addr[1:0] != 2'b00) || (upper != 32'd0);
  endfunction

endpackage

// File: rtl/memory_array.sv
// rtl/memory_array.sv - single-port synchronous RAM with write enable and registered read
module memory_array
  import memory_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage itself is never cleared; only the read register resets.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/memory_defs.vh
// rtl/memory_defs.vh - state encodings and default sizing shared by memory_unit files
`ifndef MEMORY_DEFS_VH
`define MEMORY_DEFS_VH

`define MEM_STATE_IDLE   2'd0
`define MEM_STATE_ACCESS 2'd1
`define MEM_STATE_DONE   2'd2

`define MEM_ADDR_WIDTH   8
`define MEM_WAIT_CYCLES  2

`endif

// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - fixed-latency memory controller: request FSM, fault check, tri-state read bus
module memory_unit
  import memory_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ADDR_IN,
  input  logic [31:0] MEMDATA_IN,
  output logic [31:0] MEMDATA_OUT,
  input  logic        read,
  input  logic        write,
  output logic        busy,
  output logic        mfc,
  output logic        err
);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    rd_q, wr_q, conflict_q, fault_q;
  logic                    ram_en;
  logic                    drive_out;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    mfc     = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (read || write) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        mfc     = 1'b1;
        err     = fault_q || conflict_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request is captured once in IDLE; later bus changes cannot reach the in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= 4'd0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      conflict_q <= 1'b0;
      fault_q    <= 1'b0;
    end else if (state_q == IDLE) begin
      if (read || write) begin
        cnt_q      <= 4'(WAIT_CYCLES);
        waddr_q    <= ADDR_IN[ADDR_WIDTH+1:2];
        wdata_q    <= MEMDATA_IN;
        rd_q       <= read && !write;
        wr_q       <= write && !read;
        conflict_q <= read && write;
        fault_q    <= addr_fault(ADDR_IN, ADDR_WIDTH);
      end
    end else if (state_q == ACCESS && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign ram_en = (state_q == ACCESS) && (cnt_q == 4'd0) && (rd_q || wr_q) && !fault_q;

  memory_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (ram_en),
    .we    (wr_q),
    .addr  (waddr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // A faulted read still drives the bus, but with zero instead of stale RAM data.
  assign drive_out   = (state_q == DONE) && rd_q;
  assign MEMDATA_OUT = drive_out ? (fault_q ? '0 : ram_rdata) : 'z;

endmodule

// File: tb/tb_memory_unit.sv
// tb/tb_memory_unit.sv - directed checks for memory_unit (default build and WAIT_CYCLES=0 build)
module tb_memory_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, addr0, wdata0;
  logic        read, write, read0, write0;
  logic        busy, mfc, err, busy0, mfc0, err0;
  wire  [31:0] mdo, mdo0;

  localparam logic [31:0] ZBUS = 32'hFFFF_FFFF;

  pullup (mdo);
  pullup (mdo0);

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  memory_unit #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .ADDR_IN(addr), .MEMDATA_IN(wdata), .MEMDATA_OUT(mdo),
    .read(read), .write(write), .busy(busy), .mfc(mfc), .err(err)
  );

  memory_unit #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .ADDR_IN(addr0), .MEMDATA_IN(wdata0), .MEMDATA_OUT(mdo0),
    .read(read0), .write(write0), .busy(busy0), .mfc(mfc0), .err(err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on the WAIT_CYCLES=2 unit; bus inputs are scrambled after E0.
  task automatic access(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_err, input logic [31:0] exp_mdo);
    read = rd; write = wr; addr = a; wdata = d;
    tick();
    read = 1'b0; write = 1'b0; addr = ~a; wdata = ~d;
    check({tag, "_busy_e0"}, busy, 1);
    check({tag, "_mdo_access"}, mdo, ZBUS);
    tick();
    check({tag, "_mfc_e1"}, mfc, 0);
    tick();
    check({tag, "_mfc_e2"}, mfc, 0);
    tick();
    check({tag, "_mfc_e3"}, mfc, 1);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_mdo"}, mdo, exp_mdo);
    tick();
    check({tag, "_mfc_e4"}, mfc, 0);
    check({tag, "_busy_e4"}, busy, 0);
  endtask

  initial begin
    logic [31:0] mfc_vec, busy_vec;
    reset = 1'b1;
    read = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    read0 = 1'b0; write0 = 1'b0; addr0 = '0; wdata0 = '0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_mfc", mfc, 0);
    check("rst_err", err, 0);
    check("rst_mdo", mdo, ZBUS);
    tick();
    tick();
    reset = 1'b0;
    tick();

    access("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, ZBUS);
    access("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

    access("wr00", 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 1'b0, ZBUS);
    access("rd402", 1'b1, 1'b0, 32'h402, 32'h0, 1'b1, 32'h0);
    access("rd400", 1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0);
    access("wr400", 1'b0, 1'b1, 32'h400, 32'h00000BAD, 1'b1, ZBUS);
    access("wr012", 1'b0, 1'b1, 32'h12, 32'h00000BAD, 1'b1, ZBUS);
    access("rd00", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'hCAFEF00D);
    access("rd10b", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

    access("wr20", 1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0, ZBUS);
    access("both20", 1'b1, 1'b1, 32'h20, 32'h0, 1'b1, ZBUS);
    access("rd20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h12345678);

    // Reset in the middle of ACCESS must drop the pending write.
    access("wr30", 1'b0, 1'b1, 32'h30, 32'h11111111, 1'b0, ZBUS);
    write = 1'b1; addr = 32'h30; wdata = 32'h22222222;
    tick();
    write = 1'b0;
    tick();
    #3;
    reset = 1'b1;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_mfc", mfc, 0);
    check("rstmid_err", err, 0);
    check("rstmid_mdo", mdo, ZBUS);
    tick();
    reset = 1'b0;
    tick();
    access("rd30", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h11111111);

    // Held read: accepted every 5 cycles, never queued while busy.
    read = 1'b1; addr = 32'h10;
    mfc_vec = '0; busy_vec = '0;
    for (int k = 0; k < 15; k++) begin
      tick();
      mfc_vec[k]  = mfc;
      busy_vec[k] = busy;
      if (mfc) check("hold_mdo", mdo, 32'hDEADBEEF);
    end
    read = 1'b0;
    check("hold_mfc_pattern", mfc_vec, 32'h0000_2108);
    check("hold_busy_pattern", busy_vec, 32'h0000_3DEF);
    tick();
    tick();
    check("hold_idle", busy, 0);

    // Zero-wait build: mfc in the cycle after E0+1.
    write0 = 1'b1; addr0 = 32'h4; wdata0 = 32'hA5A5A5A5;
    tick();
    write0 = 1'b0; wdata0 = 32'h0;
    check("w0_wr_busy", busy0, 1);
    check("w0_wr_mfc_e0", mfc0, 0);
    tick();
    check("w0_wr_mfc_e1", mfc0, 1);
    check("w0_wr_err", err0, 0);
    tick();
    check("w0_wr_mfc_e2", mfc0, 0);
    check("w0_wr_idle", busy0, 0);
    read0 = 1'b1;
    tick();
    read0 = 1'b0; addr0 = 32'h8;
    check("w0_rd_mfc_e0", mfc0, 0);
    tick();
    check("w0_rd_mfc_e1", mfc0, 1);
    check("w0_rd_mdo", mdo0, 32'hA5A5A5A5);
    tick();
    check("w0_rd_mfc_e2", mfc0, 0);
    check("w0_rd_mdo_z", mdo0, ZBUS);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
